// File: rtl/teclado_if.sv
// Request/status bundle between a keypad-press requester and teclado_emulador.
// The master issues key codes; the slave (the emulator) reports progress.
interface teclado_if;
  logic       tecla_valid;
  logic [3:0] tecla_codigo;
  logic       tecla_ready;
  logic       ocupado;
  logic       hecho;
  logic       error;

  modport master (
    output tecla_valid,
    output tecla_codigo,
    input  tecla_ready,
    input  ocupado,
    input  hecho,
    input  error
  );

  modport slave (
    input  tecla_valid,
    input  tecla_codigo,
    output tecla_ready,
    output ocupado,
    output hecho,
    output error
  );
endinterface

// File: rtl/teclado_emulador.sv
// Keypad-matrix responder: closes one row/column contact of a 4x4 keypad for a held time.
// Optional contact chatter on press/release is enabled by defining TECLADO_BOUNCE_EN.
module teclado_emulador #(
  parameter int HOLD_CYCLES   = 135_000,
  parameter int GAP_CYCLES    = 27_000,
  parameter int BOUNCE_CYCLES = 2_700,
  parameter int BOUNCE_PERIOD = 270
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  teclado_if.slave   bus
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_BP = (BOUNCE_CYCLES > BOUNCE_PERIOD) ? BOUNCE_CYCLES : BOUNCE_PERIOD;
  localparam int MAX_N  = (MAX_HG > MAX_BP) ? MAX_HG : MAX_BP;
  localparam int CNT_W  = ($clog2(MAX_N) > 0) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

`ifdef TECLADO_BOUNCE_EN
  localparam int PER_W = ($clog2(BOUNCE_PERIOD) > 0) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LD    = PER_W'(BOUNCE_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ZERO  = {PER_W{1'b0}};
`endif

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HOLD       = 3'd1,
    ST_GAP        = 3'd2,
    ST_ERR        = 3'd3
`ifdef TECLADO_BOUNCE_EN
    ,
    ST_BOUNCE_IN  = 3'd4,
    ST_BOUNCE_OUT = 3'd5
`endif
  } estado_t;

  // Returns {valid, column pattern, row pattern}; patterns are active-low one-hot.
  function automatic logic [8:0] decode_tecla(input logic [3:0] codigo);
    logic [1:0] col;
    logic [1:0] row;
    logic       ok;
    ok  = 1'b1;
    col = 2'd0;
    row = 2'd0;
    case (codigo)
      4'h1: begin col = 2'd0; row = 2'd0; end
      4'h4: begin col = 2'd0; row = 2'd1; end
      4'h7: begin col = 2'd0; row = 2'd2; end
      4'h2: begin col = 2'd1; row = 2'd0; end
      4'h5: begin col = 2'd1; row = 2'd1; end
      4'h8: begin col = 2'd1; row = 2'd2; end
      4'h0: begin col = 2'd1; row = 2'd3; end
      4'h3: begin col = 2'd2; row = 2'd0; end
      4'h6: begin col = 2'd2; row = 2'd1; end
      4'h9: begin col = 2'd2; row = 2'd2; end
      4'hE: begin col = 2'd2; row = 2'd3; end
      4'hA: begin col = 2'd3; row = 2'd0; end
      4'hB: begin col = 2'd3; row = 2'd1; end
      4'hC: begin col = 2'd3; row = 2'd2; end
      4'hD: begin col = 2'd3; row = 2'd3; end
      default: ok = 1'b0;
    endcase
    return {ok, ~(4'b1000 >> col), ~(4'b1000 >> row)};
  endfunction

  estado_t          estado_r, estado_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [3:0]       col_pat_r, col_next_s;
  logic [3:0]       row_pat_r, row_next_s;
  logic [3:0]       filas_r, filas_next_s;
  logic             ready_r, ocupado_r, hecho_r, error_r;
  logic             hecho_next_s, error_next_s, ready_next_s;
  logic             contacto_s;
  logic [8:0]       decode_s;
`ifdef TECLADO_BOUNCE_EN
  logic             phase_r, phase_next_s;
  logic [PER_W-1:0] pcnt_r, pcnt_next_s;
`endif

  // Next-state, counters, latched target and registered-output precursors.
  always_comb begin
    estado_next_s = estado_r;
    cnt_next_s    = cnt_r;
    col_next_s    = col_pat_r;
    row_next_s    = row_pat_r;
    decode_s      = decode_tecla(bus.tecla_codigo);
`ifdef TECLADO_BOUNCE_EN
    phase_next_s  = phase_r;
    pcnt_next_s   = pcnt_r;
`endif
    case (estado_r)
      ST_IDLE: begin
        if (bus.tecla_valid && ready_r) begin
          col_next_s = decode_s[7:4];
          row_next_s = decode_s[3:0];
          if (decode_s[8]) begin
`ifdef TECLADO_BOUNCE_EN
            estado_next_s = ST_BOUNCE_IN;
            cnt_next_s    = BOUNCE_LD;
            phase_next_s  = 1'b1;
            pcnt_next_s   = PER_LD;
`else
            estado_next_s = ST_HOLD;
            cnt_next_s    = HOLD_LD;
`endif
          end else begin
            estado_next_s = ST_ERR;
            cnt_next_s    = CNT_ZERO;
          end
        end else begin
          estado_next_s = ST_IDLE;
        end
      end
`ifdef TECLADO_BOUNCE_EN
      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (pcnt_r == PER_ZERO) begin
          phase_next_s = ~phase_r;
          pcnt_next_s  = PER_LD;
        end else begin
          pcnt_next_s  = pcnt_r - 1'b1;
        end
        if (cnt_r == CNT_ZERO) begin
          if (estado_r == ST_BOUNCE_IN) begin
            estado_next_s = ST_HOLD;
            cnt_next_s    = HOLD_LD;
          end else begin
            estado_next_s = ST_GAP;
            cnt_next_s    = GAP_LD;
          end
        end else begin
          cnt_next_s = cnt_r - 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
`ifdef TECLADO_BOUNCE_EN
          estado_next_s = ST_BOUNCE_OUT;
          cnt_next_s    = BOUNCE_LD;
          phase_next_s  = 1'b1;
          pcnt_next_s   = PER_LD;
`else
          estado_next_s = ST_GAP;
          cnt_next_s    = GAP_LD;
`endif
        end else begin
          cnt_next_s = cnt_r - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          estado_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r - 1'b1;
        end
      end
      ST_ERR: begin
        estado_next_s = ST_IDLE;
      end
      default: begin
        estado_next_s = ST_IDLE;
        cnt_next_s    = CNT_ZERO;
      end
    endcase

`ifdef TECLADO_BOUNCE_EN
    contacto_s = (estado_r == ST_HOLD) ||
                 (((estado_r == ST_BOUNCE_IN) || (estado_r == ST_BOUNCE_OUT)) && phase_r);
`else
    contacto_s = (estado_r == ST_HOLD);
`endif
    // Anything but the exact target strobe (including multi-low or idle) reads as open.
    filas_next_s = (contacto_s && (columnas == col_pat_r)) ? row_pat_r : 4'b1111;
    // Status outputs are registered, so they are derived from the state being entered.
    error_next_s = (estado_next_s == ST_ERR);
    hecho_next_s = error_next_s || ((estado_next_s == ST_GAP) && (cnt_next_s == CNT_ZERO));
    ready_next_s = (estado_next_s == ST_IDLE);
  end

  // State and output registers; reset opens the contact immediately and drops any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r  <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      col_pat_r <= 4'b1111;
      row_pat_r <= 4'b1111;
      filas_r   <= 4'b1111;
      ready_r   <= 1'b1;
      ocupado_r <= 1'b0;
      hecho_r   <= 1'b0;
      error_r   <= 1'b0;
`ifdef TECLADO_BOUNCE_EN
      phase_r   <= 1'b1;
      pcnt_r    <= PER_ZERO;
`endif
    end else begin
      estado_r  <= estado_next_s;
      cnt_r     <= cnt_next_s;
      col_pat_r <= col_next_s;
      row_pat_r <= row_next_s;
      filas_r   <= filas_next_s;
      ready_r   <= ready_next_s;
      ocupado_r <= ~ready_next_s;
      hecho_r   <= hecho_next_s;
      error_r   <= error_next_s;
`ifdef TECLADO_BOUNCE_EN
      phase_r   <= phase_next_s;
      pcnt_r    <= pcnt_next_s;
`endif
    end
  end

  assign filas           = filas_r;
  assign bus.tecla_ready = ready_r;
  assign bus.ocupado     = ocupado_r;
  assign bus.hecho       = hecho_r;
  assign bus.error       = error_r;

endmodule

// File: tb/tb_teclado_emulador.sv
// Scoreboard bench for teclado_emulador: stimulus pushes expected filas/status and
// hecho events; a monitor pops and compares them on the falling clock edge.
module tb_teclado_emulador;

  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int BNC  = 6;
  localparam int PER  = 2;
`ifdef TECLADO_BOUNCE_EN
  localparam int HOFS       = 24;
  localparam int HOLD_START = 7;
`else
  localparam int HOFS       = 12;
  localparam int HOLD_START = 1;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] f;
    bit         chk;
    bit         rdy;
  } fexp_t;

  typedef struct {
    int cyc;
    bit err;
  } hexp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] columnas;
  logic [3:0] filas;
  int         cyc;
  int         checks;
  int         failures;
  bit         done;
  bit         fin;
  fexp_t      fq[$];
  hexp_t      hq[$];

  teclado_if bus();

  teclado_emulador #(
    .HOLD_CYCLES  (HOLD),
    .GAP_CYCLES   (GAP),
    .BOUNCE_CYCLES(BNC),
    .BOUNCE_PERIOD(PER)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .columnas(columnas),
    .filas   (filas),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Contact state k cycles after the acceptance cycle, written out by hand.
  function automatic bit contact(input int k);
`ifdef TECLADO_BOUNCE_EN
    if (k >= 1 && k <= 6)        return (((k - 1) / 2) % 2) == 0;
    else if (k >= 7 && k <= 14)  return 1'b1;
    else if (k >= 15 && k <= 20) return (((k - 15) / 2) % 2) == 0;
    else                         return 1'b0;
`else
    return (k >= 1) && (k <= 8);
`endif
  endfunction

  function automatic logic [3:0] rot(input int k);
    case (k % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic press(input logic [3:0] code, input logic [3:0] tcol, input logic [3:0] trow,
                       input bit valid_code, input bit rotate, input logic [3:0] fixcol,
                       input int len, input bit with_hecho);
    int         t;
    int         hofs;
    logic [3:0] prev;
    logic [3:0] f;
    hofs = valid_code ? HOFS : 1;
    @(negedge clk);
    t = cyc;
    bus.tecla_valid  = 1'b1;
    bus.tecla_codigo = code;
    columnas = rotate ? rot(0) : fixcol;
    for (int k = 1; k <= len; k++) begin
      prev = rotate ? rot(k - 1) : fixcol;
      f = (valid_code && contact(k - 1) && (prev == tcol)) ? trow : 4'b1111;
      fq.push_back('{t + k, f, (k == 1) || (k == hofs + 1), (k == hofs + 1)});
    end
    if (with_hecho) hq.push_back('{t + hofs, !valid_code});
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      bus.tecla_valid = 1'b0;
      columnas = rotate ? rot(k) : fixcol;
    end
  endtask

  // Monitor: compares every expectation whose cycle has arrived, and every hecho pulse.
  initial begin
    fexp_t fe;
    hexp_t he;
    checks   = 0;
    failures = 0;
    fin      = 1'b0;
    forever begin
      @(negedge clk);
      while (fq.size() > 0 && fq[0].cyc <= cyc) begin
        fe = fq.pop_front();
        checks++;
        if (fe.cyc != cyc || filas !== fe.f) begin
          failures++;
          $display("FAIL filas cyc=%0d want_cyc=%0d got=%b exp=%b", cyc, fe.cyc, filas, fe.f);
        end
        if (fe.chk) begin
          checks++;
          if (bus.tecla_ready !== fe.rdy || bus.ocupado !== !fe.rdy) begin
            failures++;
            $display("FAIL ready cyc=%0d got ready=%b ocupado=%b exp ready=%b", cyc,
                     bus.tecla_ready, bus.ocupado, fe.rdy);
          end
        end
      end
      if (bus.hecho === 1'b1) begin
        checks++;
        if (hq.size() == 0) begin
          failures++;
          $display("FAIL hecho_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          he = hq.pop_front();
          if (he.cyc != cyc || bus.error !== he.err) begin
            failures++;
            $display("FAIL hecho cyc=%0d exp_cyc=%0d got error=%b exp error=%b", cyc, he.cyc,
                     bus.error, he.err);
          end
        end
      end else if (bus.hecho !== 1'b0 || bus.error !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL status cyc=%0d got hecho=%b error=%b exp 0/0", cyc, bus.hecho, bus.error);
      end
      if (hq.size() > 0 && hq[0].cyc < cyc) begin
        he = hq.pop_front();
        checks++;
        failures++;
        $display("FAIL hecho_missing cyc=%0d got=0 exp=1", he.cyc);
      end
      if (done && !fin) begin
        checks += 2;
        if (fq.size() != 0) begin
          failures++;
          $display("FAIL pending_filas got=%0d exp=0", fq.size());
        end
        if (hq.size() != 0) begin
          failures++;
          $display("FAIL pending_hecho got=%0d exp=0", hq.size());
        end
        fin = 1'b1;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int t;
    int t2;
    cyc              = 0;
    done             = 1'b0;
    rst_n            = 1'b0;
    columnas         = 4'b1011;
    bus.tecla_valid  = 1'b0;
    bus.tecla_codigo = 4'h0;
    fq.push_back('{1, 4'b1111, 1'b1, 1'b1});
    fq.push_back('{2, 4'b1111, 1'b1, 1'b1});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Code 5 (c1,r1) with a fixed column-1 strobe.
    press(4'h5, 4'b1011, 4'b1011, 1'b1, 1'b0, 4'b1011, HOFS + 2, 1'b1);
    // Code D (c3,r3) against a rotating scan.
    press(4'hD, 4'b1110, 4'b1110, 1'b1, 1'b1, 4'b1111, HOFS + 2, 1'b1);
    // Unmappable code: error pulse, no contact.
    press(4'hF, 4'b0111, 4'b0111, 1'b0, 1'b0, 4'b0111, 3, 1'b1);
    // Code 1 (c0,r0); chatter shows up only in the bounce build.
    press(4'h1, 4'b0111, 4'b0111, 1'b1, 1'b0, 4'b0111, HOFS + 2, 1'b1);

    // Valid held high while busy: the second code (3 -> c2,r0) waits, then is taken.
    @(negedge clk);
    t  = cyc;
    t2 = t + HOFS + 1;
    bus.tecla_valid  = 1'b1;
    bus.tecla_codigo = 4'h2;
    columnas         = 4'b1101;
    hq.push_back('{t + HOFS, 1'b0});
    hq.push_back('{t2 + HOFS, 1'b0});
    for (int c = t + 1; c <= t2 + HOFS + 1; c++) begin
      fq.push_back('{c, contact(c - 1 - t2) ? 4'b0111 : 4'b1111,
                     (c == t2) || (c == t2 + 1), (c == t2)});
    end
    @(negedge clk);
    bus.tecla_codigo = 4'h3;
    repeat (HOFS) @(negedge clk);
    @(negedge clk);
    bus.tecla_valid = 1'b0;
    repeat (HOFS + 1) @(negedge clk);

    // Code 8 (c1,r2), reset pulsed during HOLD: contact opens at once, no hecho.
    press(4'h8, 4'b1011, 4'b1101, 1'b1, 1'b0, 4'b1011, HOLD_START + 2, 1'b0);
    @(posedge clk);
    #2;
    fq.push_back('{cyc, 4'b1111, 1'b1, 1'b1});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(4'h8, 4'b1011, 4'b1101, 1'b1, 1'b0, 4'b1011, HOFS + 2, 1'b1);

    done = 1'b1;
    repeat (3) @(negedge clk);
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL monitor_final got=0 exp=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/teclado_emulador.md
# teclado_emulador

Keypad-matrix responder: the device side of the 4x4 column-scan/row-sense interface driven by the keypad scanner. It accepts a key code over a valid/ready handshake and closes the matching row/column contact for a programmed hold time. While the contact is closed it answers the scanner's column strobes with the correct active-low row pattern. It sits in simulation benches and hardware loopback builds in place of the physical keypad.

## Interface
- `HOLD_CYCLES`, default 135_000: contact-closed duration in clk cycles (5 ms @ 27 MHz; must exceed one full 4-column scan).
- `GAP_CYCLES`, default 27_000: open-contact settling time after release, before `hecho`.
- `BOUNCE_CYCLES`, default 2_700: length of each bounce window (press and release); used only with the macro.
- `BOUNCE_PERIOD`, default 270: contact toggle interval inside a bounce window.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `columnas` input 4: scanner column strobe, active-low one-hot (0111=col0, 1011=col1, 1101=col2, 1110=col3).
- `filas` output 4: row sense, active-low (0111=row0 … 1110=row3); 1111 means no contact.
- `tecla_valid` input 1: press request.
- `tecla_codigo` input 4: key to press.
- `tecla_ready` output 1: high only in IDLE.
- `ocupado` output 1: high in any state other than IDLE.
- `hecho` output 1: one-cycle pulse when a request completes.
- `error` output 1: one-cycle pulse, coincident with `hecho`, for an unmappable code.

## Operation
- Code map (code -> col,row):
  - 1 -> c0,r0; 4 -> c0,r1; 7 -> c0,r2.
  - 2 -> c1,r0; 5 -> c1,r1; 8 -> c1,r2; 0 -> c1,r3.
  - 3 -> c2,r0; 6 -> c2,r1; 9 -> c2,r2; E(#) -> c2,r3.
  - A -> c3,r0; B -> c3,r1; C -> c3,r2; D -> c3,r3.
  - 1111 is invalid. The c0,r3 ('*') position is not reachable.
- Accept on `tecla_valid && tecla_ready`. Code, target column and row are latched at acceptance; `tecla_codigo` is ignored otherwise.
- States: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
  - Without the macro, the BOUNCE states are skipped: IDLE -> HOLD -> GAP.
  - Invalid code: IDLE -> ERR (one cycle, `hecho`=`error`=1) -> IDLE. No contact closes.
- Each timed state lasts exactly N cycles (N = its parameter). The down-counter is loaded with N-1 on entry and the state exits when the counter reaches 0. Counter width is $clog2 of the largest parameter.
- Contact closed means one of:
  - state HOLD, or
  - BOUNCE_IN/BOUNCE_OUT while the bounce phase bit is 1. The phase bit starts at 1 on entry and inverts every `BOUNCE_PERIOD` cycles.
- `filas` next value:
  - the target row pattern if the contact is closed and `columnas` equals the target column pattern exactly;
  - otherwise 1111.
  - Multiple-low or all-high `columnas` -> 1111.
- `hecho` pulses on the last cycle of GAP. IDLE is re-entered on the following cycle.
- Reset values: `filas`=1111, `tecla_ready`=1, `ocupado`=0, `hecho`=0, `error`=0, state IDLE.
- Reset asserted mid-press: `filas` goes to 1111 asynchronously and the request is dropped with no `hecho`.

## Timing
- Acceptance edge at cycle T: `tecla_ready`=0 and `ocupado`=1 from T+1.
- `filas` is registered: one cycle latency from `columnas`/state to `filas`.
- No bounce: the contact is visible for `columnas` sampled in cycles T+1 … T+HOLD_CYCLES. It appears on `filas` in T+2 … T+HOLD_CYCLES+1.
- `hecho` cycle:
  - no bounce: T+HOLD_CYCLES+GAP_CYCLES;
  - with bounce: T+HOLD_CYCLES+GAP_CYCLES+2·BOUNCE_CYCLES.
- `tecla_ready` returns high one cycle after `hecho`, so back-to-back requests have a one-cycle IDLE minimum.
- Invalid code: `hecho`/`error` at T+1, ready at T+2.
- `tecla_valid` held high with ready low is held off, not lost.

## Configuration
- `TECLADO_BOUNCE_EN` defined: BOUNCE_IN/BOUNCE_OUT states are present and the contact chatters as specified.
- `TECLADO_BOUNCE_EN` undefined: the bounce states, phase bit and `BOUNCE_*` logic are compiled out, giving clean press/release.

## Test plan
Bench parameters: HOLD=8, GAP=4, BOUNCE=6, PERIOD=2.
- Reset: drive `rst_n`=0 with `columnas`=1011 -> `filas`=1111, `tecla_ready`=1, `ocupado`=0.
- No macro, code 5, `columnas` fixed 1011 -> `filas`=1011 for exactly 8 cycles starting T+2; `hecho` at T+12; `error`=0.
- No macro, code D, `columnas` rotating 0111/1011/1101/1110 each cycle -> `filas`=1110 only the cycle after a 1110 strobe, else 1111.
- Code 1111 -> `hecho`=`error`=1 at T+1; `filas` stays 1111; ready at T+2.
- Macro on, code 1, `columnas`=0111 -> `filas` pattern 0111,0111,1111,1111,0111,0111, then 8×0111, then the same 6-cycle chatter; `hecho` at T+24.
- Code 8 accepted, `rst_n` pulsed low during HOLD -> `filas`=1111 immediately, no `hecho`; a new request is accepted after release.
